// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder: FSM encoding, wait-counter
// width and the address decode helpers used by the top level.
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        WAIT = 2'b01,
        RESP = 2'b10
    } state_e;

    localparam int CNT_W = 4;

    function automatic logic [31:0] word_index(input logic [31:0] addr,
                                               input logic [31:0] base);
        return (addr - base) >> 32'd2;
    endfunction

    // Unsigned compares throughout: an address below base must not wrap into range.
    function automatic logic addr_fault(input logic [31:0] addr,
                                        input logic [31:0] base,
                                        input logic [31:0] depth_words);
        return (addr < base) ||
               (word_index(addr, base) >= depth_words) ||
               (addr[1:0] != 2'b00);
    endfunction

endpackage

// File: rtl/dmem_array.sv
// Word-addressed backing store with per-byte-lane write enables and an
// asynchronous read port. Contents start at zero and survive reset.
module dmem_array #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int          AW          = $clog2(DEPTH_WORDS)
) (
    input  logic          clk,
    input  logic [3:0]    we,
    input  logic [AW-1:0] waddr,
    input  logic [31:0]   wdata,
    input  logic [AW-1:0] raddr,
    output logic [31:0]   rdata
);

    logic [31:0] mem_q [DEPTH_WORDS] = '{default: 32'h0000_0000};

    // Byte-lane write port
    always_ff @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (we[b]) begin
                mem_q[waddr][8*b +: 8] <= wdata[8*b +: 8];
            end
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/dmem_resp.sv
// Single-outstanding memory responder: accepts a request, stalls WAIT_CYCLES,
// then pulses mem_ready for one cycle with read data or a fault indication.
module dmem_resp
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_valid,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic [3:0]  mem_wstrb,
    output logic [31:0] mem_rdata,
    output logic        mem_ready,
    output logic        mem_err
);

    localparam int AW = $clog2(DEPTH_WORDS);
    localparam logic [CNT_W-1:0] WAIT_INIT = CNT_W'(WAIT_CYCLES);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      addr_q, addr_d;
    logic [31:0]      wdata_q, wdata_d;
    logic [3:0]       wstrb_q, wstrb_d;
    logic             ready_q, ready_d;
    logic             err_q, err_d;
    logic [31:0]      rdata_q, rdata_d;

    logic [31:0]      lk_addr_s;
    logic [3:0]       lk_wstrb_s;
    logic             lk_fault_s;
    logic [AW-1:0]    rd_idx_s;
    logic [AW-1:0]    wr_idx_s;
    logic [31:0]      arr_rdata_s;
    logic [3:0]       we_s;
    logic             go_resp_s;

    // With zero wait the response is formed straight from the live request.
    assign lk_addr_s  = (state_q == IDLE) ? mem_addr  : addr_q;
    assign lk_wstrb_s = (state_q == IDLE) ? mem_wstrb : wstrb_q;
    assign lk_fault_s = addr_fault(lk_addr_s, BASE_ADDR, 32'(DEPTH_WORDS));
    assign rd_idx_s   = AW'(word_index(lk_addr_s, BASE_ADDR));
    assign wr_idx_s   = AW'(word_index(addr_q, BASE_ADDR));
    assign we_s       = (state_q == RESP && !rst && !err_q) ? wstrb_q : 4'b0000;

    dmem_array #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .AW          (AW)
    ) u_array (
        .clk   (clk),
        .we    (we_s),
        .waddr (wr_idx_s),
        .wdata (wdata_q),
        .raddr (rd_idx_s),
        .rdata (arr_rdata_s)
    );

    // Next-state, request latch and response formation
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        go_resp_s = 1'b0;
        case (state_q)
            IDLE: begin
                if (mem_valid) begin
                    addr_d  = mem_addr;
                    wdata_d = mem_wdata;
                    wstrb_d = mem_wstrb;
                    cnt_d   = WAIT_INIT;
                    if (WAIT_INIT != {CNT_W{1'b0}}) begin
                        state_d = WAIT;
                    end else begin
                        state_d   = RESP;
                        go_resp_s = 1'b1;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            WAIT: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q <= CNT_W'(1)) begin
                    state_d   = RESP;
                    go_resp_s = 1'b1;
                end else begin
                    state_d = WAIT;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = {CNT_W{1'b0}};
            end
        endcase

        if (go_resp_s) begin
            ready_d = 1'b1;
            err_d   = lk_fault_s;
            rdata_d = (lk_fault_s || lk_wstrb_s != 4'b0000) ? 32'h0000_0000 : arr_rdata_s;
        end else begin
            ready_d = 1'b0;
            err_d   = 1'b0;
            rdata_d = 32'h0000_0000;
        end
    end

    // FSM state, latched request and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= {CNT_W{1'b0}};
            addr_q  <= 32'h0000_0000;
            wdata_q <= 32'h0000_0000;
            wstrb_q <= 4'b0000;
            ready_q <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= 32'h0000_0000;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wstrb_q <= wstrb_d;
            ready_q <= ready_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
        end
    end

    assign mem_ready = ready_q;
    assign mem_err   = err_q;
    assign mem_rdata = rdata_q;

endmodule

// File: tb/tb_dmem_resp.sv
// Randomised bench for dmem_resp: three instances (1, 0 and 3 wait cycles)
// checked against a flat-array memory model applying the access rules directly.
module tb_dmem_resp;

    localparam int DEPTH = 64;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst       [3];
    logic        mem_valid [3];
    logic [31:0] mem_addr  [3];
    logic [31:0] mem_wdata [3];
    logic [3:0]  mem_wstrb [3];
    logic [31:0] mem_rdata [3];
    logic        mem_ready [3];
    logic        mem_err   [3];

    int          wcyc [3] = '{1, 0, 3};
    logic [31:0] ref_mem [3][DEPTH];
    int          total = 0;
    int          bad   = 0;

    dmem_resp #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(32'h0), .WAIT_CYCLES(1)) dut0 (
        .clk(clk), .rst(rst[0]), .mem_valid(mem_valid[0]), .mem_addr(mem_addr[0]),
        .mem_wdata(mem_wdata[0]), .mem_wstrb(mem_wstrb[0]), .mem_rdata(mem_rdata[0]),
        .mem_ready(mem_ready[0]), .mem_err(mem_err[0]));
    dmem_resp #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(32'h0), .WAIT_CYCLES(0)) dut1 (
        .clk(clk), .rst(rst[1]), .mem_valid(mem_valid[1]), .mem_addr(mem_addr[1]),
        .mem_wdata(mem_wdata[1]), .mem_wstrb(mem_wstrb[1]), .mem_rdata(mem_rdata[1]),
        .mem_ready(mem_ready[1]), .mem_err(mem_err[1]));
    dmem_resp #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(32'h0), .WAIT_CYCLES(3)) dut2 (
        .clk(clk), .rst(rst[2]), .mem_valid(mem_valid[2]), .mem_addr(mem_addr[2]),
        .mem_wdata(mem_wdata[2]), .mem_wstrb(mem_wstrb[2]), .mem_rdata(mem_rdata[2]),
        .mem_ready(mem_ready[2]), .mem_err(mem_err[2]));

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Reference: fault rules, then byte-merge or read on the flat array.
    task automatic model(input int d, input logic [31:0] a, input logic [31:0] wd,
                         input logic [3:0] ws, output logic e, output logic [31:0] r);
        int idx;
        if (a[1:0] != 2'b00 || a >= 32'(4 * DEPTH)) begin
            e = 1'b1;
            r = 32'h0;
        end else begin
            e   = 1'b0;
            idx = int'(a / 32'd4);
            if (ws == 4'b0000) begin
                r = ref_mem[d][idx];
            end else begin
                r = 32'h0;
                for (int b = 0; b < 4; b++)
                    if (ws[b]) ref_mem[d][idx][8*b +: 8] = wd[8*b +: 8];
            end
        end
    endtask

    function automatic logic [34:0] obs(input int d);
        return {1'b0, mem_ready[d], mem_err[d], mem_rdata[d]};
    endfunction

    // One transaction; inputs are scrambled right after acceptance.
    task automatic do_req(input int d, input logic [31:0] a, input logic [31:0] wd,
                          input logic [3:0] ws, input string tag);
        logic        e;
        logic [31:0] r;
        int          w;
        w = wcyc[d];
        model(d, a, wd, ws, e, r);
        @(negedge clk);
        mem_valid[d] = 1'b1; mem_addr[d] = a; mem_wdata[d] = wd; mem_wstrb[d] = ws;
        @(posedge clk);
        #1;
        mem_valid[d] = 1'b0;
        mem_addr[d]  = $urandom;
        mem_wdata[d] = $urandom;
        mem_wstrb[d] = 4'($urandom_range(0, 15));
        for (int n = 1; n <= w + 2; n++) begin
            @(negedge clk);
            if (n == w + 1) chk({tag, " resp"}, 64'(obs(d)), 64'({1'b0, 1'b1, e, r}));
            else            chk({tag, " quiet"}, 64'(obs(d)), 64'h0);
        end
    endtask

    function automatic logic [31:0] rand_addr();
        logic [31:0] a;
        case ($urandom_range(0, 9))
            7:       a = 32'(4 * $urandom_range(0, 15) + $urandom_range(1, 3));
            8:       a = 32'(4 * DEPTH + 4 * $urandom_range(0, 7));
            9:       a = ($urandom | 32'h8000_0000) & 32'hFFFF_FFFC;
            default: a = 32'(4 * $urandom_range(0, 15));
        endcase
        return a;
    endfunction

    initial begin
        for (int d = 0; d < 3; d++) begin
            rst[d] = 1'b1; mem_valid[d] = 1'b0; mem_addr[d] = 32'h0;
            mem_wdata[d] = 32'h0; mem_wstrb[d] = 4'h0;
            for (int i = 0; i < DEPTH; i++) ref_mem[d][i] = 32'h0;
        end
        repeat (2) @(posedge clk);
        #1;
        for (int d = 0; d < 3; d++) rst[d] = 1'b0;
        @(negedge clk);
        for (int d = 0; d < 3; d++) chk("reset outputs", 64'(obs(d)), 64'h0);

        // Abort a 3-wait write to 0x40 with reset during WAIT
        @(negedge clk);
        mem_valid[2] = 1'b1; mem_addr[2] = 32'h40; mem_wdata[2] = 32'hCAFE_F00D; mem_wstrb[2] = 4'hF;
        @(posedge clk);
        #1;
        mem_valid[2] = 1'b0;
        @(negedge clk);
        rst[2] = 1'b1;
        @(negedge clk);
        chk("rst outputs", 64'(obs(2)), 64'h0);
        rst[2] = 1'b0;
        for (int n = 0; n < 6; n++) begin
            @(negedge clk);
            chk("aborted no ready", 64'(obs(2)), 64'h0);
        end
        do_req(2, 32'h40, 32'h0, 4'h0, "aborted read 0x40");

        // Directed cases on the one-wait instance
        do_req(0, 32'h10, 32'hDEAD_BEEF, 4'hF, "wr 0x10");
        do_req(0, 32'h10, 32'h0, 4'h0, "rd 0x10");
        do_req(0, 32'h20, 32'h1122_3344, 4'hF, "wr 0x20");
        do_req(0, 32'h20, 32'hAABB_CCDD, 4'h5, "strb 0x20");
        do_req(0, 32'h20, 32'h0, 4'h0, "rd 0x20 merged");
        do_req(0, 32'h13, 32'h0, 4'h0, "misaligned rd");
        do_req(0, 32'(4 * DEPTH), 32'h0, 4'h0, "oor rd");
        do_req(0, 32'h11, 32'h5555_5555, 4'hF, "misaligned wr");
        do_req(0, 32'(4 * DEPTH), 32'h6666_6666, 4'hF, "oor wr");
        do_req(0, 32'h10, 32'h0, 4'h0, "rd 0x10 unchanged");

        // Zero-wait back-to-back reads with mem_valid held high
        for (int i = 0; i < 3; i++)
            do_req(1, 32'(4 * i), $urandom, 4'hF, "preload");
        @(negedge clk);
        mem_valid[1] = 1'b1; mem_wstrb[1] = 4'h0;
        for (int i = 0; i < 3; i++) begin
            mem_addr[1] = 32'(4 * i);
            @(posedge clk);
            @(negedge clk);
            chk("b2b resp", 64'(obs(1)), 64'({1'b0, 1'b1, 1'b0, ref_mem[1][i]}));
            if (i == 2) mem_valid[1] = 1'b0;
            @(negedge clk);
            chk("b2b gap", 64'(obs(1)), 64'h0);
        end

        // Random traffic across all instances
        for (int k = 0; k < 150; k++) begin
            int d;
            d = $urandom_range(0, 2);
            do_req(d, rand_addr(), $urandom,
                   ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15)), "random");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
